// File: rtl/rgb_led_driver.sv
// RGB LED driver: debounces the comparator colour flags, dims with PWM and
// flashes the newly accepted colour for a fixed number of blinks.
module rgb_led_driver #(
  parameter int PWM_BITS      = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int BLINK_CYCLES  = 8,
  parameter int BLINK_COUNT   = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                red_in,
  input  logic                green_in,
  input  logic                blue_in,
  input  logic [PWM_BITS-1:0] brightness,
  output logic                red_led,
  output logic                green_led,
  output logic                blue_led,
  output logic                busy
);

  localparam int SW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam int TW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam int BW = $clog2(BLINK_COUNT + 1);
  localparam logic [SW-1:0] SMAX = SW'(STABLE_CYCLES - 1);
  localparam logic [TW-1:0] TMAX = TW'(BLINK_CYCLES - 1);
  localparam logic [BW-1:0] BMAX = BW'(BLINK_COUNT);

  typedef enum logic [1:0] {STEADY, BLINK_OFF, BLINK_ON} state_t;

  logic [2:0]          w_in3;
  logic [2:0]          r_cand;
  logic [2:0]          r_acc;
  logic [SW-1:0]       r_scnt;
  logic                w_chg;
  logic [PWM_BITS-1:0] r_pcnt;
  logic [PWM_BITS-1:0] r_bq;
  logic                w_pwm_on;
  state_t              r_state;
  state_t              w_next_state;
  logic [TW-1:0]       r_tcnt;
  logic [TW-1:0]       w_tcnt_nxt;
  logic [BW-1:0]       r_bcnt;
  logic [BW-1:0]       w_bcnt_nxt;
  logic [BW-1:0]       w_bcnt_inc;
  logic [2:0]          r_led;
  logic                r_busy;

  assign w_in3 = {red_in, green_in, blue_in};
  // chg fires on the same edge that copies cand into acc
  assign w_chg = (w_in3 == r_cand) && (r_scnt == SMAX) && (r_cand != r_acc);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cand <= 3'b000;
      r_acc  <= 3'b000;
      r_scnt <= '0;
    end else if (w_in3 != r_cand) begin
      r_cand <= w_in3;
      r_scnt <= '0;
    end else if (r_scnt < SMAX) begin
      r_scnt <= r_scnt + SW'(1);
    end else if (r_cand != r_acc) begin
      r_acc <= r_cand;
    end
  end

  // Brightness is latched only at the period boundary to avoid partial periods
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pcnt <= '0;
      r_bq   <= '0;
    end else begin
      r_pcnt <= r_pcnt + PWM_BITS'(1);
      if (r_pcnt == '1) r_bq <= brightness;
    end
  end

  assign w_pwm_on = (r_pcnt < r_bq);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= STEADY;
      r_tcnt  <= '0;
      r_bcnt  <= '0;
    end else begin
      r_state <= w_next_state;
      r_tcnt  <= w_tcnt_nxt;
      r_bcnt  <= w_bcnt_nxt;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_tcnt_nxt   = r_tcnt;
    w_bcnt_nxt   = r_bcnt;
    w_bcnt_inc   = r_bcnt + BW'(1);
    if (w_chg) begin
      w_next_state = BLINK_OFF;
      w_tcnt_nxt   = '0;
      w_bcnt_nxt   = '0;
    end else begin
      case (r_state)
        STEADY: begin
          w_next_state = STEADY;
        end
        BLINK_OFF: begin
          if (r_tcnt == TMAX) begin
            w_next_state = BLINK_ON;
            w_tcnt_nxt   = '0;
          end else begin
            w_tcnt_nxt = r_tcnt + TW'(1);
          end
        end
        BLINK_ON: begin
          if (r_tcnt == TMAX) begin
            w_bcnt_nxt   = w_bcnt_inc;
            w_tcnt_nxt   = '0;
            w_next_state = (w_bcnt_inc == BMAX) ? STEADY : BLINK_OFF;
          end else begin
            w_tcnt_nxt = r_tcnt + TW'(1);
          end
        end
        default: begin
          w_next_state = STEADY;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_led  <= 3'b000;
      r_busy <= 1'b0;
    end else begin
      r_led  <= r_acc & {3{w_pwm_on}} & {3{w_next_state != BLINK_OFF}};
      r_busy <= (w_next_state != STEADY);
    end
  end

  assign red_led   = r_led[2];
  assign green_led = r_led[1];
  assign blue_led  = r_led[0];
  assign busy      = r_busy;

endmodule

// File: tb/tb_rgb_led_driver.sv
// Directed bench for rgb_led_driver: filter, blink sequence, PWM duty,
// retrigger and mid-sequence reset.
module tb_rgb_led_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       red_in, green_in, blue_in;
  logic [3:0] brightness;
  logic       red_led, green_led, blue_led, busy;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference PWM phase and latched brightness, advanced once per edge
  logic [3:0] pc = 4'd0;
  logic [3:0] bq = 4'd0;
  logic       pwm_exp = 1'b0;

  rgb_led_driver dut (
    .clk        (clk),
    .rst        (rst),
    .red_in     (red_in),
    .green_in   (green_in),
    .blue_in    (blue_in),
    .brightness (brightness),
    .red_led    (red_led),
    .green_led  (green_led),
    .blue_led   (blue_led),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic [2:0] v);
    {red_in, green_in, blue_in} = v;
  endtask

  task automatic tick();
    pwm_exp = (pc < bq);
    @(posedge clk);
    if (rst) begin
      pc = 4'd0;
      bq = 4'd0;
    end else begin
      if (pc == 4'hF) bq = brightness;
      pc = pc + 4'd1;
    end
    #1;
  endtask

  task automatic check_out(input string tag, input logic [2:0] col, input logic on,
                           input logic busy_exp);
    logic [2:0] e;
    e = on ? (col & {3{pwm_exp}}) : 3'b000;
    check({tag, ".led"}, 32'({red_led, green_led, blue_led}), 32'(e));
    check({tag, ".busy"}, 32'(busy), 32'(busy_exp));
  endtask

  // Cycle 1 is the state right after the accepting edge; on-phases are 9-16 and 25-32
  task automatic blink_run(input logic [2:0] col, input int last);
    for (int n = 1; n <= last; n++) begin
      if (n > 1) tick();
      check_out($sformatf("blink%0d", n), col, ((n - 1) / 8) % 2 == 1, 1'b1);
    end
  endtask

  task automatic accept_from_steady(input logic [2:0] old_col, input logic [2:0] new_col);
    set_in(new_col);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_out("acc_wait", old_col, 1'b1, 1'b0);
    end
    tick();
  endtask

  task automatic duty_window(input string tag, input int exp_cnt);
    int c;
    c = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      check_out(tag, 3'b100, 1'b1, 1'b0);
      c += int'(red_led);
    end
    check({tag, ".count"}, c, exp_cnt);
  endtask

  initial begin
    rst = 1'b1;
    set_in(3'b010);
    brightness = 4'd15;

    tick(); check_out("rst0", 3'b000, 1'b0, 1'b0);
    tick(); check_out("rst1", 3'b000, 1'b0, 1'b0);
    rst = 1'b0;
    tick(); check_out("release", 3'b000, 1'b0, 1'b0);

    set_in(3'b000);
    repeat (2) tick();
    set_in(3'b010);
    repeat (3) tick();
    set_in(3'b000);
    for (int i = 0; i < 8; i++) begin
      tick(); check_out("glitch3", 3'b010, 1'b0, 1'b0);
    end

    // Four edges of 010 is one short of acceptance
    set_in(3'b010);
    repeat (4) tick();
    set_in(3'b000);
    for (int i = 0; i < 8; i++) begin
      tick(); check_out("glitch4", 3'b010, 1'b0, 1'b0);
    end

    accept_from_steady(3'b000, 3'b010);
    blink_run(3'b010, 32);
    tick(); check_out("steady_g", 3'b010, 1'b1, 1'b0);

    accept_from_steady(3'b010, 3'b100);
    blink_run(3'b100, 32);
    tick(); check_out("steady_r", 3'b100, 1'b1, 1'b0);

    brightness = 4'd4;
    for (int i = 0; i < 16; i++) begin
      tick(); check_out("settle4", 3'b100, 1'b1, 1'b0);
    end
    duty_window("duty4", 4);
    brightness = 4'd0;
    for (int i = 0; i < 16; i++) begin
      tick(); check_out("settle0", 3'b100, 1'b1, 1'b0);
    end
    duty_window("duty0", 0);
    brightness = 4'd15;
    for (int i = 0; i < 16; i++) begin
      tick(); check_out("settle15", 3'b100, 1'b1, 1'b0);
    end
    duty_window("duty15", 15);

    for (int i = 0; i < 16 && pc != 4'd8; i++) tick();
    brightness = 4'd0;
    tick(); check("mid_hold", 32'(red_led), 32'd1);
    for (int i = 0; i < 16 && pc != 4'd0; i++) begin
      tick(); check_out("mid_wait", 3'b100, 1'b1, 1'b0);
    end
    tick(); check("mid_apply", 32'(red_led), 32'd0);

    brightness = 4'd15;
    accept_from_steady(3'b100, 3'b010);
    blink_run(3'b010, 26);
    set_in(3'b001);
    for (int i = 0; i < 4; i++) begin
      tick(); check_out("retrig_wait", 3'b010, 1'b1, 1'b1);
    end
    tick();
    blink_run(3'b001, 32);
    tick(); check_out("steady_b", 3'b001, 1'b1, 1'b0);

    accept_from_steady(3'b001, 3'b010);
    blink_run(3'b010, 12);
    rst = 1'b1;
    tick(); check_out("mid_rst", 3'b000, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick(); check_out("reacc_wait", 3'b000, 1'b0, 1'b0);
    end
    tick();
    blink_run(3'b010, 32);
    tick(); check_out("steady_end", 3'b010, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
